// File: rtl/alu_uart_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_uart_sequencer                                         |
// | Description : Takes operand A, operand B and an opcode from the UART     |
// |               receiver, pulses the registered ALU's load strobes, waits  |
// |               out the ALU latency, captures the result and starts the    |
// |               UART transmitter with it.                                  |
// | Revision    : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module alu_uart_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_done,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  input  logic [NB_DATA-1:0] alu_R,
  output logic [NB_DATA-1:0] buf_A,
  output logic [NB_DATA-1:0] buf_B,
  output logic [NB_OP-1:0]   buf_Op,
  output logic               p_a,
  output logic               p_b,
  output logic               p_c,
  output logic               busy,
  output logic               op_err
);

  // Counter must hold ALU_LAT; keep at least one bit even for zero latency.
  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [NB_OP-1:0] C_OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] C_OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] C_OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] C_OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] C_OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] C_OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] C_OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] C_OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_WAIT = 3'd3,
    S_TX   = 3'd4,
    S_TXW  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] buf_a_q, buf_a_d;
  logic [NB_DATA-1:0] buf_b_q, buf_b_d;
  logic [NB_OP-1:0]   buf_op_q, buf_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               p_a_q, p_a_d;
  logic               p_b_q, p_b_d;
  logic               p_c_q, p_c_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               op_err_q, op_err_d;
  logic               w_op_valid;

  // An opcode byte is accepted only with clear upper bits and a known ALU function.
  function automatic logic op_is_valid(input logic [NB_DATA-1:0] b);
    logic [NB_OP-1:0] op;
    op = b[NB_OP-1:0];
    if (b[NB_DATA-1:NB_OP] != '0) return 1'b0;
    case (op)
      C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR,
      C_OP_XOR, C_OP_NOR, C_OP_SRA, C_OP_SRL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  assign w_op_valid = op_is_valid(rx_data);

  // State and output registers; reset clears everything, even mid-command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      cnt_q      <= '0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      buf_op_q   <= '0;
      tx_data_q  <= '0;
      p_a_q      <= 1'b0;
      p_b_q      <= 1'b0;
      p_c_q      <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      buf_op_q   <= buf_op_d;
      tx_data_q  <= tx_data_d;
      p_a_q      <= p_a_d;
      p_b_q      <= p_b_d;
      p_c_q      <= p_c_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      op_err_q   <= op_err_d;
    end
  end

  // Next-state and next-output logic; pulses default low, data defaults to hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    buf_op_d   = buf_op_q;
    tx_data_d  = tx_data_q;
    p_a_d      = 1'b0;
    p_b_d      = 1'b0;
    p_c_d      = 1'b0;
    tx_start_d = 1'b0;
    op_err_d   = 1'b0;

    case (state_q)
      S_A: begin
        if (rx_done) begin
          buf_a_d = rx_data;
          p_a_d   = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (rx_done) begin
          buf_b_d = rx_data;
          p_b_d   = 1'b1;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (rx_done) begin
          if (w_op_valid) begin
            buf_op_d = rx_data[NB_OP-1:0];
            p_c_d    = 1'b1;
            cnt_d    = CNT_W'(ALU_LAT);
            state_d  = S_WAIT;
          end else begin
            // Bad opcode: leave the ALU alone and restart the command.
            op_err_d = 1'b1;
            state_d  = S_A;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          tx_data_d = alu_R;
          state_d   = S_TX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TX: begin
        tx_start_d = 1'b1;
        state_d    = S_TXW;
      end
      S_TXW: begin
        if (tx_done) state_d = S_A;
      end
      default: state_d = S_A;
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d == S_WAIT) || (state_d == S_TX) || (state_d == S_TXW);
  end

  assign buf_A    = buf_a_q;
  assign buf_B    = buf_b_q;
  assign buf_Op   = buf_op_q;
  assign tx_data  = tx_data_q;
  assign p_a      = p_a_q;
  assign p_b      = p_b_q;
  assign p_c      = p_c_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign op_err   = op_err_q;

endmodule
`default_nettype wire
